// File: rtl/decode_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : decode_ctrl_pkg                                        |
// | Description : Shared types and constants for the decode controller:  |
// |               FSM state encoding, opcode/funct codes, datapath       |
// |               select codes.                                          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package decode_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_BR = 2'd2
  } state_t;

  // Opcodes
  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_J   = 2'b01;
  localparam logic [1:0] OP_R   = 2'b11;

  // Register-format branch function codes
  localparam logic [4:0] FUNCT_R_A = 5'b00011;
  localparam logic [4:0] FUNCT_R_B = 5'b00001;

  // Datapath select codes
  localparam logic [1:0] SEL_NOP = 2'b00;
  localparam logic [1:0] SEL_R_A = 2'b01;
  localparam logic [1:0] SEL_R_B = 2'b10;
  localparam logic [1:0] SEL_J   = 2'b11;

endpackage
`default_nettype wire

// File: rtl/decode_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : decode_ctrl_if                                         |
// | Description : Instruction, command and branch-status signals of the  |
// |               decode controller.                                     |
// |               slave  : controller side (decode_ctrl)                 |
// |               master : fetch/datapath side                           |
// |   ins_valid/ins_ready/ins_op/ins_funct : instruction handshake       |
// |   cmd_valid/cmd_ready/cmd_sel/cmd_b    : command handshake           |
// |   br_done                              : branch completion           |
// |   err/br_timeout/busy                  : status                      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface decode_ctrl_if;
  logic       ins_valid;
  logic       ins_ready;
  logic [1:0] ins_op;
  logic [4:0] ins_funct;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_sel;
  logic       cmd_b;
  logic       br_done;
  logic       err;
  logic       br_timeout;
  logic       busy;

  modport slave (
    input  ins_valid, ins_op, ins_funct, cmd_ready, br_done,
    output ins_ready, cmd_valid, cmd_sel, cmd_b, err, br_timeout, busy
  );

  modport master (
    output ins_valid, ins_op, ins_funct, cmd_ready, br_done,
    input  ins_ready, cmd_valid, cmd_sel, cmd_b, err, br_timeout, busy
  );
endinterface
`default_nettype wire

// File: rtl/decode_ctrl_table.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : decode_table                                           |
// | Description : Combinational op/funct decoder.                        |
// |   op      in  2 : opcode                                             |
// |   funct   in  5 : function field                                     |
// |   sel     out 2 : datapath select                                    |
// |   b       out 1 : branch flag                                        |
// |   illegal out 1 : combination not in the decode table                |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module decode_table
  import decode_ctrl_pkg::*;
(
  input  logic [1:0] op,
  input  logic [4:0] funct,
  output logic [1:0] sel,
  output logic       b,
  output logic       illegal
);

  always_comb begin
    sel     = SEL_NOP;
    b       = 1'b0;
    illegal = 1'b1;
    case (op)
      OP_NOP: begin
        illegal = 1'b0;
      end
      OP_J: begin
        sel     = SEL_J;
        b       = 1'b1;
        illegal = 1'b0;
      end
      OP_R: begin
        if (funct == FUNCT_R_A) begin
          sel     = SEL_R_A;
          b       = 1'b1;
          illegal = 1'b0;
        end else if (funct == FUNCT_R_B) begin
          sel     = SEL_R_B;
          b       = 1'b1;
          illegal = 1'b0;
        end
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/decode_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : decode_ctrl                                            |
// | Description : Sequencing controller around the instruction decoder.  |
// |               Accepts one instruction, issues its decoded command,   |
// |               and after a branch command waits for br_done (or a     |
// |               timeout) before accepting the next instruction.        |
// |   TIMEOUT      : WAIT_BR cycles before abandoning (2..255)           |
// |   clk          : clock, rising edge                                  |
// |   rst_n        : asynchronous active-low reset                       |
// |   bus (slave)  : instruction/command handshakes and status           |
// | Build option : DECODE_CTRL_TIMEOUT_EN - when defined, the WAIT_BR    |
// |                timeout counter is built; otherwise WAIT_BR waits     |
// |                for br_done indefinitely and br_timeout stays 0.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module decode_ctrl
  import decode_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  decode_ctrl_if.slave  bus
);

  if ((TIMEOUT < 2) || (TIMEOUT > 255)) begin : g_timeout_range_check
    $error("decode_ctrl: TIMEOUT must be in 2..255");
  end

  state_t     r_state, w_state_nxt;
  logic [1:0] r_cmd_sel, w_cmd_sel_nxt;
  logic       r_cmd_b, w_cmd_b_nxt;
  logic       r_err, w_err_nxt;
  logic       r_br_to, w_br_to_nxt;
  logic       w_term;

  logic [1:0] w_dec_sel;
  logic       w_dec_b;
  logic       w_dec_illegal;

  decode_table u_decode_table (
    .op      (bus.ins_op),
    .funct   (bus.ins_funct),
    .sel     (w_dec_sel),
    .b       (w_dec_b),
    .illegal (w_dec_illegal)
  );

`ifdef DECODE_CTRL_TIMEOUT_EN
  localparam int                 c_cnt_w    = $clog2(TIMEOUT);
  localparam logic [c_cnt_w-1:0] c_cnt_term = c_cnt_w'(TIMEOUT - 1);

  logic [c_cnt_w-1:0] r_wait_cnt;

  assign w_term = (r_wait_cnt == c_cnt_term);

  // Counts only while staying in WAIT_BR; any exit (including the terminal
  // cycle) clears it, so it is zero on every entry and never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if ((r_state == WAIT_BR) && (w_state_nxt == WAIT_BR)) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end else begin
      r_wait_cnt <= '0;
    end
  end
`else
  assign w_term = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cmd_sel_nxt = r_cmd_sel;
    w_cmd_b_nxt   = r_cmd_b;
    w_err_nxt     = 1'b0;
    w_br_to_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.ins_valid) begin
          if (w_dec_illegal) begin
            w_err_nxt = 1'b1;
          end else begin
            w_cmd_sel_nxt = w_dec_sel;
            w_cmd_b_nxt   = w_dec_b;
            w_state_nxt   = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (bus.cmd_ready) begin
          w_state_nxt = r_cmd_b ? WAIT_BR : IDLE;
        end
      end
      WAIT_BR: begin
        // br_done takes priority over the terminal count.
        if (bus.br_done) begin
          w_state_nxt = IDLE;
        end else if (w_term) begin
          w_br_to_nxt = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_sel <= SEL_NOP;
      r_cmd_b   <= 1'b0;
      r_err     <= 1'b0;
      r_br_to   <= 1'b0;
    end else begin
      r_cmd_sel <= w_cmd_sel_nxt;
      r_cmd_b   <= w_cmd_b_nxt;
      r_err     <= w_err_nxt;
      r_br_to   <= w_br_to_nxt;
    end
  end

  assign bus.ins_ready  = (r_state == IDLE);
  assign bus.busy       = (r_state != IDLE);
  assign bus.cmd_valid  = (r_state == ISSUE);
  assign bus.cmd_sel    = r_cmd_sel;
  assign bus.cmd_b      = r_cmd_b;
  assign bus.err        = r_err;
  assign bus.br_timeout = r_br_to;

endmodule
`default_nettype wire

// File: tb/tb_decode_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_decode_ctrl                                         |
// | Description : Self-checking bench for decode_ctrl. A cycle reference |
// |               model (pending command / branch wait / wait cycles)    |
// |               predicts every output after each clock; directed steps |
// |               cover the named scenarios, then a random stream.       |
// |               Honours DECODE_CTRL_TIMEOUT_EN like the design.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_decode_ctrl;

  localparam int c_timeout = 4;
`ifdef DECODE_CTRL_TIMEOUT_EN
  localparam bit c_to_en = 1'b1;
`else
  localparam bit c_to_en = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  decode_ctrl_if bus ();

  decode_ctrl #(.TIMEOUT(c_timeout)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  bit         m_pend;
  bit         m_brw;
  int         m_wait;
  logic [1:0] m_sel;
  logic       m_b;
  logic       m_err;
  logic       m_to;

  // Returns {illegal, b, sel[1:0]} straight from the decode rules.
  function automatic logic [3:0] ref_decode(input logic [1:0] op, input logic [4:0] fn);
    if (op == 2'b00)                    return 4'b0_0_00;
    else if (op == 2'b01)               return 4'b0_1_11;
    else if (op == 2'b11 && fn == 5'd3) return 4'b0_1_01;
    else if (op == 2'b11 && fn == 5'd1) return 4'b0_1_10;
    else                                return 4'b1_0_00;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_brw = 0; m_wait = 0;
    m_sel = 2'b00; m_b = 1'b0; m_err = 1'b0; m_to = 1'b0;
  endtask

  task automatic check_outputs(input string where);
    chk({where, ".ins_ready"},  8'(bus.ins_ready),  8'(!(m_pend || m_brw)));
    chk({where, ".busy"},       8'(bus.busy),       8'(m_pend || m_brw));
    chk({where, ".cmd_valid"},  8'(bus.cmd_valid),  8'(m_pend));
    chk({where, ".cmd_sel"},    8'(bus.cmd_sel),    8'(m_sel));
    chk({where, ".cmd_b"},      8'(bus.cmd_b),      8'(m_b));
    chk({where, ".err"},        8'(bus.err),        8'(m_err));
    chk({where, ".br_timeout"}, 8'(bus.br_timeout), 8'(m_to));
  endtask

  // Drive one cycle of inputs, advance the model, clock, then compare.
  task automatic step(input string where, input logic iv, input logic [1:0] op,
                      input logic [4:0] fn, input logic cr, input logic bd);
    logic [3:0] d;
    bus.ins_valid = iv; bus.ins_op = op; bus.ins_funct = fn;
    bus.cmd_ready = cr; bus.br_done = bd;
    m_err = 1'b0;
    m_to  = 1'b0;
    if (!m_pend && !m_brw) begin
      if (iv) begin
        d = ref_decode(op, fn);
        if (d[3]) m_err = 1'b1;
        else begin
          m_pend = 1; m_b = d[2]; m_sel = d[1:0];
        end
      end
    end else if (m_pend) begin
      if (cr) begin
        m_pend = 0;
        if (m_b) begin m_brw = 1; m_wait = 0; end
      end
    end else begin
      if (bd) m_brw = 0;
      else if (c_to_en && (m_wait == c_timeout - 1)) begin m_brw = 0; m_to = 1'b1; end
      else m_wait++;
    end
    @(posedge clk);
    #1;
    check_outputs(where);
  endtask

  task automatic check_reset_values(input string where);
    chk({where, ".ins_ready"},  8'(bus.ins_ready),  8'd1);
    chk({where, ".busy"},       8'(bus.busy),       8'd0);
    chk({where, ".cmd_valid"},  8'(bus.cmd_valid),  8'd0);
    chk({where, ".cmd_sel"},    8'(bus.cmd_sel),    8'd0);
    chk({where, ".cmd_b"},      8'(bus.cmd_b),      8'd0);
    chk({where, ".err"},        8'(bus.err),        8'd0);
    chk({where, ".br_timeout"}, 8'(bus.br_timeout), 8'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    model_reset();

    // Reset, with an instruction offered that must be ignored.
    rst_n = 1'b0;
    bus.ins_valid = 1'b1; bus.ins_op = 2'b01; bus.ins_funct = 5'd0;
    bus.cmd_ready = 1'b1; bus.br_done = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_reset_values("reset");
    bus.ins_valid = 1'b0;
    #3 rst_n = 1'b1;

    // NOP with cmd_ready tied high
    step("nop_acc",  1'b1, 2'b00, 5'b10101, 1'b1, 1'b0);
    chk("nop_sel", 8'(bus.cmd_sel), 8'h00);
    step("nop_hs",   1'b0, 2'b00, 5'd0, 1'b1, 1'b0);
    chk("nop_ready_back", 8'(bus.ins_ready), 8'd1);

    // Branch with 5 cycles of backpressure, br_done 3 cycles after WAIT_BR
    step("bp_acc", 1'b1, 2'b11, 5'b00011, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step("bp_hold", 1'b1, 2'b00, 5'd0, 1'b0, 1'b1);
    chk("bp_sel", 8'(bus.cmd_sel), 8'h01);
    step("bp_hs",  1'b0, 2'b00, 5'd0, 1'b1, 1'b0);
    step("bp_w1",  1'b0, 2'b00, 5'd0, 1'b0, 1'b0);
    step("bp_w2",  1'b0, 2'b00, 5'd0, 1'b0, 1'b0);
    step("bp_done", 1'b0, 2'b00, 5'd0, 1'b0, 1'b1);
    chk("bp_idle", 8'(bus.ins_ready), 8'd1);

    // Back-to-back illegal instructions
    step("ill_1", 1'b1, 2'b10, 5'd3, 1'b1, 1'b0);
    chk("ill_1_err", 8'(bus.err), 8'd1);
    step("ill_2", 1'b1, 2'b11, 5'b00111, 1'b1, 1'b0);
    chk("ill_2_err", 8'(bus.err), 8'd1);
    step("ill_end", 1'b0, 2'b00, 5'd0, 1'b1, 1'b0);

`ifdef DECODE_CTRL_TIMEOUT_EN
    begin
      int k_to;
      k_to = 0;
      step("to_acc", 1'b1, 2'b01, 5'd0, 1'b0, 1'b0);
      step("to_hs",  1'b0, 2'b00, 5'd0, 1'b1, 1'b0);
      for (int k = 1; k <= 8; k++) begin
        step("to_wait", 1'b0, 2'b00, 5'd0, 1'b0, 1'b0);
        if (bus.br_timeout === 1'b1) begin
          k_to = k;
          break;
        end
      end
      chk("to_latency", 8'(k_to), 8'd4);
      step("to_after", 1'b0, 2'b00, 5'd0, 1'b0, 1'b0);
      // br_done on the terminal cycle wins: no pulse
      step("tod_acc", 1'b1, 2'b01, 5'd9, 1'b1, 1'b0);
      step("tod_hs",  1'b0, 2'b00, 5'd0, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) step("tod_wait", 1'b0, 2'b00, 5'd0, 1'b0, 1'b0);
      step("tod_done", 1'b0, 2'b00, 5'd0, 1'b0, 1'b1);
      chk("tod_no_pulse", 8'(bus.br_timeout), 8'd0);
    end
`else
    step("nto_acc", 1'b1, 2'b01, 5'd0, 1'b1, 1'b0);
    step("nto_hs",  1'b0, 2'b00, 5'd0, 1'b1, 1'b0);
    for (int k = 0; k < 1000; k++) step("nto_wait", 1'b0, 2'b00, 5'd0, 1'b1, 1'b0);
    chk("nto_busy", 8'(bus.busy), 8'd1);
    step("nto_done", 1'b0, 2'b00, 5'd0, 1'b1, 1'b1);
    chk("nto_free", 8'(bus.ins_ready), 8'd1);
`endif

    // Asynchronous reset in the middle of WAIT_BR
    step("rst_acc", 1'b1, 2'b11, 5'b00011, 1'b0, 1'b0);
    step("rst_hs",  1'b0, 2'b00, 5'd0, 1'b1, 1'b0);
    step("rst_w",   1'b0, 2'b00, 5'd0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    @(posedge clk);
    #3 rst_n = 1'b1;
    model_reset();
    step("post_rst_acc", 1'b1, 2'b11, 5'b00001, 1'b0, 1'b0);
    chk("post_rst_sel", 8'(bus.cmd_sel), 8'h02);
    step("post_rst_hs", 1'b0, 2'b00, 5'd0, 1'b1, 1'b0);
    step("post_rst_done", 1'b0, 2'b00, 5'd0, 1'b0, 1'b1);

    // Random stream against the model
    for (int i = 0; i < 400; i++) begin
      logic [4:0] fn;
      case ($urandom_range(0, 3))
        0:       fn = 5'b00011;
        1:       fn = 5'b00001;
        default: fn = 5'($urandom);
      endcase
      step("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), fn,
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 4) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
